// File: rtl/dffram_host_pkg.sv
// Shared types and constants for the DFFRAM request-side controller.
package dffram_host_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned BeW   = 4;

    typedef struct packed {
        logic [DataW-1:0] rdata;
        logic             err;
    } rsp_t;

    localparam int unsigned RspW = $bits(rsp_t);

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count; push into a full FIFO is allowed when a pop
// happens in the same cycle.
module fifo_sync #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        pop_ok   = pop_i && (count_q != '0);
        push_ok  = push_i && ((count_q != CntW'(Depth)) || pop_ok);
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CntW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;

endmodule

// File: rtl/dffram_host.sv
// Request-side controller for the DFFRAM macro: drives the macro port on accept and returns
// the one-cycle-late read data in order. Optional address-range errors: DFFRAM_HOST_ERR_EN.
module dffram_host
    import dffram_host_pkg::*;
#(
    parameter int unsigned AW       = 12,
    parameter int unsigned RspDepth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [31:0]      req_addr_i,
    input  logic [BeW-1:0]   req_be_i,
    input  logic [DataW-1:0] req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DataW-1:0] rsp_rdata_o,
    output logic             rsp_err_o,
    output logic             ram_en_o,
    output logic [BeW-1:0]   ram_we_o,
    output logic [AW-1:0]    ram_addr_o,
    output logic [DataW-1:0] ram_wdata_o,
    input  logic [DataW-1:0] ram_rdata_i
);
    localparam int unsigned CntW = $clog2(RspDepth + 1);
`ifdef DFFRAM_HOST_ERR_EN
    localparam int unsigned FifoW = RspW;
`else
    localparam int unsigned FifoW = DataW;
`endif

    logic             accept, addr_err, unused_addr, unused_fifo_full;
    logic             s1_valid_q, s1_valid_d, s1_we_q, s1_we_d;
    logic [DataW-1:0] s1_rdata;
    logic [FifoW-1:0] fifo_wdata, fifo_rdata;
    logic             fifo_empty;
    logic [CntW-1:0]  fifo_count;
    logic [CntW:0]    occupancy;

    // Slots are claimed at accept, so the in-flight s1 entry counts against the FIFO.
    assign occupancy   = {1'b0, fifo_count} + {{CntW{1'b0}}, s1_valid_q};
    assign req_ready_o = rst_ni && (occupancy < (CntW + 1)'(RspDepth));
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        ram_en_o    = accept && !addr_err;
        ram_we_o    = (ram_en_o && req_we_i) ? req_be_i : '0;
        ram_addr_o  = req_addr_i[AW+1:2];
        ram_wdata_o = req_wdata_i;
        s1_valid_d  = accept;
        s1_we_d     = req_we_i;
    end

`ifdef DFFRAM_HOST_ERR_EN
    logic s1_err_q, s1_err_d;
    rsp_t head;

    assign addr_err    = |req_addr_i[31:AW+2];
    assign unused_addr = ^req_addr_i[1:0];
    assign s1_err_d    = addr_err;
    assign s1_rdata    = (s1_we_q || s1_err_q) ? '0 : ram_rdata_i;
    assign fifo_wdata  = {s1_rdata, s1_err_q};
    assign head        = rsp_t'(fifo_rdata);
    assign rsp_rdata_o = rsp_valid_o ? head.rdata : '0;
    assign rsp_err_o   = rsp_valid_o && head.err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_err_q <= 1'b0;
        end else begin
            s1_err_q <= s1_err_d;
        end
    end
`else
    assign addr_err    = 1'b0;
    assign unused_addr = ^{req_addr_i[31:AW+2], req_addr_i[1:0]};
    assign s1_rdata    = s1_we_q ? '0 : ram_rdata_i;
    assign fifo_wdata  = s1_rdata;
    assign rsp_rdata_o = rsp_valid_o ? fifo_rdata : '0;
    assign rsp_err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_we_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_we_q    <= s1_we_d;
        end
    end

    fifo_sync #(
        .Width (FifoW),
        .Depth (RspDepth)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (s1_valid_q),
        .wdata_i (fifo_wdata),
        .pop_i   (rsp_ready_i),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (unused_fifo_full),
        .count_o (fifo_count)
    );

    assign rsp_valid_o = !fifo_empty;

endmodule

// File: doc/dffram_host.md
# dffram_host

Request-side controller for the on-chip DFFRAM macro: accepts word-wide read/write requests over a valid/ready bus, drives the macro's enable/byte-mask/address/data port, and returns the one-cycle-late read data as buffered responses. It sits between the core-side bus adapter and the memory macro. Responses are returned strictly in request order with sustained single-cycle throughput.

## Interface
- AW, 12, macro word-address width (depth 2^AW words)
- RspDepth, 4, response FIFO entries (legal ≥2; ≥3 needed for one request/cycle)
- clk_i  in  1  single clock, also clocks the macro
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when valid&&ready
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  32  byte address; word index = addr[AW+1:2], addr[1:0] ignored
- req_be_i  in  4  byte enables for writes, ignored for reads
- req_wdata_i  in  32  write data
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when valid&&ready
- rsp_rdata_o  out  32  read data; 0 for writes and errors
- rsp_err_o  out  1  access error (see Configuration)
- ram_en_o  out  1  macro chip enable
- ram_we_o  out  4  macro byte write mask
- ram_addr_o  out  AW  macro word address
- ram_wdata_o  out  32  macro write data
- ram_rdata_i  in  32  macro read data, valid the cycle after ram_en_o

## Operation
- Accept: req_ready_o = rst_ni && (fifo_count + s1_valid) < RspDepth; registered state only, no path from rsp_ready_i.
- On accept (cycle T), ram_* driven combinationally in T: ram_en_o=1, ram_addr_o=word index, ram_wdata_o=req_wdata_i, ram_we_o = req_we_i ? req_be_i : 4'b0.
- No accept: ram_en_o=0, ram_we_o=0; ram_addr_o/ram_wdata_o follow request inputs (don't-care).
- Write with be=0 still occupies a slot and returns a response.
- Stage s1 (registered): valid, we, err captured at T.
- T+1: if s1 valid, push {rdata = (we||err) ? 0 : ram_rdata_i, err} into FIFO.
- rsp_* driven from FIFO head; rsp_valid_o = FIFO non-empty.
- Push and pop same cycle allowed at any count, including full (pop frees, push fills).
- Ordering: responses strictly in acceptance order.

## Timing
- Reset values: req_ready_o=0 while rst_ni low, 1 the first cycle after; rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, ram_en_o=0, ram_we_o=0, s1_valid=0, FIFO empty.
- Latency: accept at T → rsp_valid_o at T+2 when FIFO was empty.
- Throughput: one request/cycle with RspDepth≥3 and rsp_ready_i held high; RspDepth=2 gives one per 2 cycles.
- Backpressure: with rsp_ready_i low, at most RspDepth requests outstanding; req_ready_o drops the cycle after the last slot is claimed.
- Reset mid-operation: in-flight s1 and FIFO contents discarded, no response ever produced for them; RAM writes already issued remain in memory.
- rsp_rdata_o/rsp_err_o stable while rsp_valid_o && !rsp_ready_i.

## Configuration
- DFFRAM_HOST_ERR_EN defined: request with req_addr_i[31:AW+2] ≠ 0 is accepted, ram_en_o held 0 for it, response returned with rsp_err_o=1, rsp_rdata_o=0, same latency/ordering.
- Undefined: upper address bits ignored (address wraps modulo 2^AW words), rsp_err_o tied 0, no err bit stored in s1/FIFO.

## Structure
- dffram_host_pkg: rsp entry struct {rdata[31:0], err}, DataW=32, BeW=4 constants.
- One sub-module: fifo_sync (parameterised width/depth, count output, push/pop same cycle) for response buffering; s1 stage and ram drive in top.

## Test plan
- Write addr 0x10, be=4'hF, data 0xDEADBEEF, then read 0x10 → ram_we_o=4'hF/ram_addr_o=4 at accept; read response 0xDEADBEEF, err=0, write response rdata=0, each at T+2.
- Partial write be=4'b0101 data 0x11223344 over 0xFFFFFFFF, read back → 0xFF22FF44.
- 16 back-to-back reads, rsp_ready_i=1, RspDepth=4 → req_ready_o never drops, 16 in-order responses on consecutive cycles.
- rsp_ready_i=0 while issuing 6 reads → exactly 4 accepted, req_ready_o=0 thereafter; release → 4 in-order responses then remaining 2 accepted.
- With DFFRAM_HOST_ERR_EN, read addr 0x0000_4000 (AW=12) → ram_en_o=0, response err=1, rdata=0; without macro → reads word 0.
- Assert rst_ni low with 3 responses pending → rsp_valid_o=0 immediately, no stale responses after release.
